// File: rtl/cic_interp_param_if.sv
// cic_interp_param_if
//   Sample stream bundle for cic_interp_param.
//   i_data   : signed input sample (Win bits), source -> block
//   val_in   : input valid, source -> block
//   in_ready : block can accept a sample this cycle, block -> source
//   o_data   : signed registered output sample (Wout bits), block -> sink
//   val_out  : o_data valid, block -> sink
//   modport slave  : the interpolator side
//   modport master : the sample source / sink side
interface cic_interp_param_if #(
  parameter int Win  = 16,
  parameter int Wout = 16
);
  logic signed [Win-1:0]  i_data;
  logic                   val_in;
  logic                   in_ready;
  logic signed [Wout-1:0] o_data;
  logic                   val_out;

  modport slave (
    input  i_data, val_in,
    output in_ready, o_data, val_out
  );

  modport master (
    output i_data, val_in,
    input  in_ready, o_data, val_out
  );
endinterface

// File: rtl/cic_interp_param.sv
// cic_interp_param
//   Parametrised CIC interpolator: N combs at the input rate, zero-stuffing
//   by R, N integrators at the output rate, round-half-up right shift by
//   SHIFT, then narrowing to Wout bits.
//   Build option: define CIC_SAT_EN to clip the rounded result to the Wout
//   signed range; otherwise the result is truncated (two's-complement wrap).
// Ports
//   clk : clock, rising edge
//   rst : synchronous reset, active low
//   bus : cic_interp_param_if.slave (i_data/val_in in, in_ready/o_data/val_out out)
module cic_interp_param #(
  parameter int Win   = 16,
  parameter int Wout  = 16,
  parameter int N     = 3,
  parameter int R     = 8,
  parameter int Wg    = 8,
  parameter int SHIFT = 6
) (
  input  logic              clk,
  input  logic              rst,
  cic_interp_param_if.slave bus
);

  localparam int Wc   = Win + N;
  localparam int Wacc = Win + Wg;
  localparam int Wr   = Wacc + 1;
  localparam int PW   = (R > 1) ? $clog2(R) : 1;

  // HALF is zero when SHIFT=0, so the rounding add vanishes.
  localparam logic signed [Wr-1:0] HALF = Wr'((64'(1) << SHIFT) >> 1);
  localparam logic signed [Wr-1:0] OMAX = Wr'((64'(1) << (Wout - 1)) - 64'(1));
  localparam logic signed [Wr-1:0] OMIN = ~OMAX;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                 state_q;
  logic [PW-1:0]          phase_q;
  logic                   ready_q;
  logic                   accept;
  logic signed [Wc-1:0]   comb_q [N];
  logic signed [Wc-1:0]   comb_d [N+1];
  logic signed [Wc-1:0]   hold_q;
  logic signed [Wacc-1:0] int_q [N];
  logic signed [Wacc-1:0] stuff_d;
  logic [N:0]             vld_q;
  logic signed [Wout-1:0] out_q;
  logic signed [Wout-1:0] out_d;
  logic signed [Wr-1:0]   rnd_d;
  logic signed [Wr-1:0]   r_d;

  // ready_q is the registered FSM output; gating with rst forces it low
  // while reset is held and lets it show 1 immediately after release.
  assign bus.in_ready = rst & ready_q;
  assign accept       = bus.val_in & bus.in_ready;
  assign bus.o_data   = out_q;
  assign bus.val_out  = vld_q[N];

  always_comb begin
    comb_d[0] = Wc'(bus.i_data);
    for (int unsigned k = 0; k < N; k++) begin
      comb_d[k+1] = comb_d[k] - comb_q[k];
    end
  end

  assign stuff_d = (state_q == RUN && phase_q == '0) ? Wacc'(hold_q) : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      phase_q <= '0;
      ready_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= RUN;
            phase_q <= '0;
            ready_q <= 1'b0;
          end
        end
        RUN: begin
          if (phase_q == PW'(R - 1)) begin
            phase_q <= '0;
            if (accept) begin
              ready_q <= 1'b0;
            end else begin
              state_q <= IDLE;
              ready_q <= 1'b1;
            end
          end else begin
            phase_q <= phase_q + 1'b1;
            ready_q <= (phase_q == PW'(R - 2));
          end
        end
        default: begin
          state_q <= IDLE;
          phase_q <= '0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned k = 0; k < N; k++) begin
        comb_q[k] <= '0;
        int_q[k]  <= '0;
      end
      hold_q <= '0;
      vld_q  <= '0;
      out_q  <= '0;
    end else begin
      if (accept) begin
        for (int unsigned k = 0; k < N; k++) begin
          comb_q[k] <= comb_d[k];
        end
        hold_q <= comb_d[N];
      end
      int_q[0] <= int_q[0] + stuff_d;
      for (int unsigned k = 1; k < N; k++) begin
        int_q[k] <= int_q[k] + int_q[k-1];
      end
      vld_q <= {vld_q[N-1:0], (state_q == RUN)};
      // Output register loads only for valid samples so o_data holds between bursts.
      if (vld_q[N-1]) begin
        out_q <= out_d;
      end
    end
  end

  always_comb begin
    rnd_d = Wr'(int_q[N-1]) + HALF;
    r_d   = rnd_d >>> SHIFT;
`ifdef CIC_SAT_EN
    if (r_d > OMAX) begin
      out_d = Wout'(OMAX);
    end else if (r_d < OMIN) begin
      out_d = Wout'(OMIN);
    end else begin
      out_d = Wout'(r_d);
    end
`else
    out_d = Wout'(r_d);
`endif
  end

endmodule

// File: tb/tb_cic_interp_param.sv
module tb_cic_interp_param;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cic_interp_param_if #(.Win(16), .Wout(16)) bus ();
  cic_interp_param_if #(.Win(16), .Wout(16)) bus5 ();

  cic_interp_param #(.Win(16), .Wout(16), .N(3), .R(8), .Wg(8), .SHIFT(6)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  cic_interp_param #(.Win(16), .Wout(16), .N(3), .R(8), .Wg(8), .SHIFT(5)) dut5 (
    .clk(clk), .rst(rst), .bus(bus5)
  );

  int n_vec = 0;
  int n_err = 0;

  longint sbq [$];
  longint xin [$];
  longint xq  [$];
  longint pq  [$];
  longint cap [$];
  longint out_sum = 0;

  bit       st_run = 0;
  int       ph     = 0;
  logic [4:0] rh   = '0;
  longint   cyc    = 0;

  // Impulse response of the default filter (3 cascaded length-8 boxes).
  int h_tab [22] = '{1, 3, 6, 10, 15, 21, 28, 36, 42, 46, 48,
                     48, 46, 42, 36, 28, 21, 15, 10, 6, 3, 1};

`ifdef CIC_SAT_EN
  longint sat_exp = 32767;
`else
  longint sat_exp = -2;
`endif

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint binom(input longint n);
    return (n + 2) * (n + 1) / 2;
  endfunction

  // Closed form: each comb output is an impulse into three cascaded
  // integrators, whose response at lag n is C(n+2,2).
  function automatic longint model_out(input longint p);
    longint acc = 0;
    longint r;
    logic signed [15:0] w;
    for (int i = 0; i < xq.size(); i++) begin
      if (pq[i] <= p) acc += xq[i] * binom(p - pq[i]);
    end
    r = (acc + 32) >>> 6;
`ifdef CIC_SAT_EN
    if (r > 32767) r = 32767;
    else if (r < -32768) r = -32768;
`else
    w = r[15:0];
    r = w;
`endif
    return r;
  endfunction

  function automatic longint xhist(input int back);
    int n = xin.size();
    if (back >= n) return 0;
    return xin[n - 1 - back];
  endfunction

  task automatic accept_model(input longint d, input longint p);
    longint xc;
    xin.push_back(d);
    xc = xhist(0) - 3 * xhist(1) + 3 * xhist(2) - xhist(3);
    xq.push_back(xc);
    pq.push_back(p);
    for (int m = 0; m < 8; m++) sbq.push_back(model_out(p + m));
  endtask

  task automatic cycle(input logic v, input logic signed [15:0] d);
    bit rdy;
    bit acc_now;
    bus.val_in = v;
    bus.i_data = d;
    rdy = !st_run || (ph == 7);
    chk("in_ready", bus.in_ready, rdy);
    acc_now = v && rdy;
    if (acc_now) accept_model(d, cyc);
    @(posedge clk);
    #1;
    if (acc_now) begin
      st_run = 1;
      ph = 0;
    end else if (st_run) begin
      if (ph == 7) st_run = 0;
      else ph++;
    end
    rh = {rh[3:0], st_run};
    chk("val_out", bus.val_out, rh[4]);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 16'sd0);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    bus.val_in = 1'b0;
    bus.i_data = '0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
    sbq.delete(); xin.delete(); xq.delete(); pq.delete();
    st_run = 0; ph = 0; rh = '0;
    chk("rst_o_data", bus.o_data, 0);
    chk("rst_val_out", bus.val_out, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    rst = 1'b1;
    #1;
    chk("release_in_ready", bus.in_ready, 1);
  endtask

  // Scoreboard monitor: pops one expected sample per valid output.
  always @(negedge clk) begin
    if (bus.val_out) begin
      if (sbq.size() == 0) begin
        chk("unexpected_val_out", bus.val_out, 0);
      end else begin
        chk("o_data", bus.o_data, sbq.pop_front());
        out_sum += bus.o_data;
        cap.push_back(bus.o_data);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.val_in  = 1'b0;
    bus.i_data  = '0;
    bus5.val_in = 1'b1;
    bus5.i_data = 16'sd32767;

    // Reset state and release.
    do_reset(3);

    // Latency / handshake: single accept of 100.
    cycle(1'b1, 16'sd100);
    idle(20);
    chk("latency_drained", sbq.size(), 0);

    // Impulse: 64 then zeros back-to-back.
    do_reset(2);
    cap.delete();
    out_sum = 0;
    cycle(1'b1, 16'sd64);
    for (int i = 0; i < 31; i++) cycle(1'b1, 16'sd0);
    idle(16);
    chk("impulse_count", cap.size(), 32);
    for (int i = 0; i < 22; i++) begin
      if (i < cap.size()) chk($sformatf("impulse_h%0d", i), cap[i], h_tab[i]);
    end
    chk("impulse_sum", out_sum, 512);

    // DC step of 1000, continuous accepts.
    do_reset(2);
    cap.delete();
    for (int i = 0; i < 80; i++) cycle(1'b1, 16'sd1000);
    chk("dc_steady", bus.o_data, 1000);
    idle(16);

    // Gapped input: -500 every 12 cycles, stray val_in while not ready.
    do_reset(2);
    for (int j = 0; j < 4; j++) begin
      cycle(1'b1, -16'sd500);
      for (int n = 1; n < 12; n++) cycle((n == 2 || n == 5), 16'sd12345);
    end
    idle(16);

    // Reset mid-burst at phase 3, then a fresh accept of 1000.
    do_reset(2);
    cycle(1'b1, 16'sd1000);
    idle(3);
    do_reset(1);
    cycle(1'b1, 16'sd1000);
    idle(40);

    // Saturation instance (SHIFT=5, continuous 32767) is in steady state.
    for (int i = 0; i < 16; i++) begin
      chk("sat_o_data", bus5.o_data, sat_exp);
      chk("sat_val_out", bus5.val_out, 1);
      cycle(1'b0, 16'sd0);
    end

    chk("scoreboard_empty", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
